// File: rtl/data_mem_port.sv
// data_mem_port: load/store responder for the single-cycle RISC-V datapath.
// Byte/half/word accesses on a little-endian word array, with sign/zero
// extension on loads and error responses for misaligned or illegal accesses.
module data_mem_port #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mr,
    input  logic        mwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_RD   = 3'd1;
    localparam logic [2:0] LOAD_RSP  = 3'd2;
    localparam logic [2:0] STORE_ACK = 3'd3;
    localparam logic [2:0] ERR_ACK   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] widx;
    logic          accept;
    logic          is_load;
    logic          is_store;
    logic          f3_ok;
    logic          align_ok;
    logic          req_err;
    logic          do_load;
    logic          do_store;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   ld_word;
    logic [2:0]    ld_f3;
    logic [1:0]    ld_lane;
    logic [31:0]   ld_shifted;
    logic [31:0]   ld_ext;
    logic          unused_addr_bits;

    // Upper address bits fold away so the array wraps modulo its byte size.
    assign widx             = addr[AW+1:2];
    assign unused_addr_bits = ^addr[31:AW+2];

    assign is_load  = mr && !mwrite;
    assign is_store = mwrite && !mr;
    assign accept   = req_valid && req_ready && (mr || mwrite);
    assign do_load  = accept && is_load && !req_err;
    assign do_store = accept && is_store && !req_err;

    // Legality check: direction, funct3 encoding and natural alignment.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = is_load;
            default:                f3_ok = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   align_ok = !addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        req_err = !(is_load || is_store) || !f3_ok || !align_ok;
    end

    // Store lane steering: alignment is already guaranteed, so one byte
    // shift places byte, half and word data in their lanes.
    always_comb begin
        wlanes = wdata << {addr[1:0], 3'b000};
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr[1:0];
            2'b01:   be = 4'b0011 << addr[1:0];
            default: be = 4'b1111;
        endcase
    end

    // Array write with byte enables; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    // Capture the addressed word and access shape when a load is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_word <= '0;
            ld_f3   <= '0;
            ld_lane <= '0;
        end else if (do_load) begin
            ld_word <= mem[widx];
            ld_f3   <= funct3;
            ld_lane <= addr[1:0];
        end
    end

    // Lane extract and sign/zero extension of the latched word.
    always_comb begin
        ld_shifted = ld_word >> {ld_lane, 3'b000};
        case (ld_f3)
            3'b000:  ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            3'b001:  ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            3'b100:  ld_ext = {24'b0, ld_shifted[7:0]};
            3'b101:  ld_ext = {16'b0, ld_shifted[15:0]};
            default: ld_ext = ld_shifted;
        endcase
    end

    // Load result register: only a completed load changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (state == LOAD_RD) begin
            rdata <= ld_ext;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: every response state lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)      state_nxt = ERR_ACK;
                    else if (is_load) state_nxt = LOAD_RD;
                    else              state_nxt = STORE_ACK;
                end
            end
            LOAD_RD:   state_nxt = LOAD_RSP;
            LOAD_RSP:  state_nxt = IDLE;
            STORE_ACK: state_nxt = IDLE;
            ERR_ACK:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are masked by reset so a pending response is dropped.
    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = ((state == LOAD_RSP) || (state == STORE_ACK) ||
                         (state == ERR_ACK)) && !rst;
    assign resp_err   = (state == ERR_ACK) && !rst;

endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed vectors for data_mem_port with hand-computed
// expected values for loads, stores, errors, wrap, back-pressure and reset.
module tb_data_mem_port;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mr;
    logic        mwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        resp_err;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] lastRdata  = 32'h0;

    data_mem_port #(.DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mr         (mr),
        .mwrite     (mwrite),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        else
            passCount++;
    endtask

    // Present one request in IDLE and hold it across the accepting edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input string tag);
        @(negedge clk);
        checkOutput({tag, " ready"}, {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        mr        = rd;
        mwrite    = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mr        = 1'b0;
        mwrite    = 1'b0;
    endtask

    // Store: acknowledged without error one cycle after acceptance.
    task automatic doStore(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
        applyStimulus(1'b0, 1'b1, f3, a, wd, tag);
        @(negedge clk);
        checkOutput({tag, " resp_valid"}, {31'b0, resp_valid}, 32'h1);
        checkOutput({tag, " resp_err"}, {31'b0, resp_err}, 32'h0);
    endtask

    // Load: silent in T+1, response with data in T+2.
    task automatic doLoad(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] expected, input string tag);
        applyStimulus(1'b1, 1'b0, f3, a, 32'h0, tag);
        @(negedge clk);
        checkOutput({tag, " busy resp_valid"}, {31'b0, resp_valid}, 32'h0);
        checkOutput({tag, " busy ready"}, {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        checkOutput({tag, " resp_valid"}, {31'b0, resp_valid}, 32'h1);
        checkOutput({tag, " resp_err"}, {31'b0, resp_err}, 32'h0);
        checkOutput({tag, " rdata"}, rdata, expected);
        lastRdata = expected;
    endtask

    // Rejected access: error response in T+1, rdata untouched.
    task automatic doError(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input string tag);
        applyStimulus(rd, wr, f3, a, 32'hFFFF_FFFF, tag);
        @(negedge clk);
        checkOutput({tag, " resp_valid"}, {31'b0, resp_valid}, 32'h1);
        checkOutput({tag, " resp_err"}, {31'b0, resp_err}, 32'h1);
        checkOutput({tag, " rdata"}, rdata, lastRdata);
    endtask

    // Directed test sequence.
    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        mr        = 1'b0;
        mwrite    = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;

        // Reset held for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("reset ready", {31'b0, req_ready}, 32'h0);
            checkOutput("reset resp_valid", {31'b0, resp_valid}, 32'h0);
            checkOutput("reset rdata", rdata, 32'h0);
        end
        rst = 1'b0;
        #1;
        checkOutput("post-reset ready", {31'b0, req_ready}, 32'h1);
        checkOutput("post-reset resp_valid", {31'b0, resp_valid}, 32'h0);

        // Word store then load.
        doStore(3'b010, 32'h10, 32'hDEAD_BEEF, "sw 0x10");
        doLoad(3'b010, 32'h10, 32'hDEAD_BEEF, "lw 0x10");

        // Partial stores and extending loads.
        doStore(3'b000, 32'h11, 32'h0000_007F, "sb 0x11");
        doStore(3'b001, 32'h12, 32'h0000_8001, "sh 0x12");
        doLoad(3'b010, 32'h10, 32'h8001_7FEF, "lw merged");
        doLoad(3'b000, 32'h13, 32'hFFFF_FF80, "lb 0x13");
        doLoad(3'b100, 32'h13, 32'h0000_0080, "lbu 0x13");
        doLoad(3'b001, 32'h12, 32'hFFFF_8001, "lh 0x12");
        doLoad(3'b101, 32'h12, 32'h0000_8001, "lhu 0x12");
        doLoad(3'b000, 32'h10, 32'hFFFF_FFEF, "lb 0x10");

        // Error cases, then confirm the word is intact.
        doError(1'b1, 1'b0, 3'b010, 32'h12, "lw misaligned");
        doError(1'b1, 1'b0, 3'b001, 32'h11, "lh misaligned");
        doError(1'b0, 1'b1, 3'b010, 32'h13, "sw misaligned");
        doError(1'b1, 1'b0, 3'b011, 32'h10, "load f3=011");
        doError(1'b0, 1'b1, 3'b100, 32'h10, "store f3=100");
        doError(1'b1, 1'b1, 3'b010, 32'h10, "mr and mwrite");
        doLoad(3'b010, 32'h10, 32'h8001_7FEF, "lw after errors");

        // Address wrap at 4*DEPTH bytes.
        doStore(3'b010, 32'h100, 32'h1234_5678, "sw 0x100");
        doLoad(3'b010, 32'h000, 32'h1234_5678, "lw wrap 0x000");

        // Request with neither strobe is ignored.
        @(negedge clk);
        req_valid = 1'b1;
        mr        = 1'b0;
        mwrite    = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("no-strobe resp_valid", {31'b0, resp_valid}, 32'h0);
            checkOutput("no-strobe ready", {31'b0, req_ready}, 32'h1);
        end
        req_valid = 1'b0;

        // Back-to-back loads: second is held until the response cycle passes.
        @(negedge clk);
        req_valid = 1'b1;
        mr        = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h10;
        checkOutput("b2b first ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        addr = 32'h000;
        @(negedge clk);
        checkOutput("b2b LOAD_RD ready", {31'b0, req_ready}, 32'h0);
        checkOutput("b2b LOAD_RD resp_valid", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        checkOutput("b2b LOAD_RSP ready", {31'b0, req_ready}, 32'h0);
        checkOutput("b2b first resp_valid", {31'b0, resp_valid}, 32'h1);
        checkOutput("b2b first rdata", rdata, 32'h8001_7FEF);
        @(negedge clk);
        checkOutput("b2b second accept ready", {31'b0, req_ready}, 32'h1);
        checkOutput("b2b idle resp_valid", {31'b0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        mr        = 1'b0;
        @(negedge clk);
        checkOutput("b2b second busy ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        checkOutput("b2b second resp_valid", {31'b0, resp_valid}, 32'h1);
        checkOutput("b2b second rdata", rdata, 32'h1234_5678);
        lastRdata = 32'h1234_5678;

        // Reset during LOAD_RD drops the response.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, "lw then reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid-reset ready", {31'b0, req_ready}, 32'h0);
        @(negedge clk);
        checkOutput("mid-reset resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("mid-reset rdata", rdata, 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("release ready", {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        checkOutput("release resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("release ready idle", {31'b0, req_ready}, 32'h1);
        lastRdata = 32'h0;

        // Array contents survive reset.
        doLoad(3'b010, 32'h10, 32'h8001_7FEF, "lw after reset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
